// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and status/error record types for sync_fifo_prog
// Contents: DEF_DATA_WIDTH/DEF_DEPTH defaults, fifo_status_t flag bundle, err_t sticky error bundle.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic half_full;
    } fifo_status_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage array, synchronous write, asynchronous read
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata combinational read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable thresholds, occupancy count, sticky errors and flush
// Ports: clk, rstn (synchronous, active-low); wr_enb/wr_data push; rd_enb/rd_data pop;
//   flush empties the FIFO; err_clr clears overflow/underflow; af_thresh/ae_thresh program
//   almost_full/almost_empty; level/full/empty/almost_full/almost_empty/half_full report occupancy.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is a
//   registered read with one cycle of latency.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_enb,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_enb,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic [ADDR_W:0]       af_thresh,
    input  logic [ADDR_W:0]       ae_thresh,
    output logic [ADDR_W:0]       level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  half_full,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] HALF_LVL = (ADDR_W + 1)'(DEPTH / 2);

    logic [ADDR_W:0]       r_wptr;
    logic [ADDR_W:0]       r_rptr;
    logic [ADDR_W:0]       r_level;
    err_t                  r_err;
    fifo_status_t          w_status;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ov_set;
    logic                  w_un_set;
    logic                  w_unused;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Flags depend only on the registered level and the live thresholds.
    always_comb begin
        w_status.full         = r_level == FULL_LVL;
        w_status.empty        = r_level == '0;
        w_status.almost_full  = r_level >= af_thresh;
        w_status.almost_empty = r_level <= ae_thresh;
        w_status.half_full    = r_level >= HALF_LVL;
    end

    // A flush cycle ignores both requests and raises no errors.
    assign w_rd_acc = rd_enb && !w_status.empty && !flush;
    assign w_wr_acc = wr_enb && (!w_status.full || w_rd_acc) && !flush;
    assign w_ov_set = wr_enb && !w_wr_acc && !flush;
    assign w_un_set = rd_enb && !w_rd_acc && !flush;

    // Occupancy comes from r_level, so the pointer wrap bits carry no control duty here.
    assign w_unused = r_wptr[ADDR_W] ^ r_rptr[ADDR_W];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_err   <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + ONE;
            if (w_rd_acc) r_rptr <= r_rptr + ONE;
            if (w_wr_acc != w_rd_acc) r_level <= w_wr_acc ? r_level + ONE : r_level - ONE;
            // A new error in the same cycle wins over err_clr.
            r_err.overflow  <= w_ov_set | (r_err.overflow & ~err_clr);
            r_err.underflow <= w_un_set | (r_err.underflow & ~err_clr);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[ADDR_W-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rptr[ADDR_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; meaningless while empty.
    assign rd_data = w_mem_rdata;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (!rstn) r_rd_data <= '0;
        else if (w_rd_acc) r_rd_data <= w_mem_rdata;
    end

    assign rd_data = r_rd_data;
`endif

    assign level        = r_level;
    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign half_full    = w_status.half_full;
    assign overflow     = r_err.overflow;
    assign underflow    = r_err.underflow;
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO, the next generation of the team's FIFO buffer.
- Adds over the previous generation: generic depth, runtime-programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error bits and a synchronous flush.
- Sits between a producer and consumer in the same clock domain; its status outputs feed the existing monitor/scoreboard flag checks.

Parameters:
DATA_WIDTH, 8, word width in bits.
DEPTH, 16, number of entries; power of two, at least 4.
ADDR_W, $clog2(DEPTH), derived; memory address width.

Ports:
clk  in  1  single clock; all logic on posedge.
rstn  in  1  synchronous reset, active-low.
wr_enb  in  1  write request.
wr_data  in  DATA_WIDTH  write word.
rd_enb  in  1  read request.
rd_data  out  DATA_WIDTH  read word.
flush  in  1  synchronous empty command.
err_clr  in  1  clears the sticky error bits.
af_thresh  in  ADDR_W+1  almost_full threshold.
ae_thresh  in  ADDR_W+1  almost_empty threshold.
level  out  ADDR_W+1  occupancy, 0..DEPTH.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
almost_full  out  1  level >= af_thresh.
almost_empty  out  1  level <= ae_thresh.
half_full  out  1  level >= DEPTH/2.
overflow  out  1  sticky: a write was rejected.
underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rstn=0 at a posedge): pointers=0, level=0, rd_data=0, overflow=0, underflow=0. Resulting flags: empty=1, almost_empty=1, full/almost_full/half_full=0. Memory contents are not cleared.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit. level is a registered up/down counter, not derived from pointer subtraction.
- Write accepted (wr_acc) when wr_enb && (!full || rd_acc). The word is stored at wptr and wptr increments.
- Read accepted (rd_acc) when rd_enb && !empty.
- Default mode: rd_data is registered and loaded from mem[rptr] on the edge of rd_acc (1-cycle latency). rd_data holds its value when no read is accepted.
- Simultaneous wr_acc and rd_acc: level is unchanged.
  - When full: the read frees a slot, so the write is accepted with no overflow.
  - When empty: the write is accepted, the read is rejected, underflow is set and level becomes 1.
- Level update: +1 on wr_acc only; −1 on rd_acc only.
- overflow set on wr_enb && !wr_acc; underflow set on rd_enb && !rd_acc. err_clr clears both; a set has priority over err_clr in the same cycle.
- flush=1: next edge sets pointers=0 and level=0. Any wr/rd that cycle is ignored and sets no error. rd_data and the sticky bits are unchanged. rstn has priority over flush.
- All flags are combinational functions of the registered level and the threshold inputs only; there is no path from wr_enb/rd_enb.
- Thresholds are sampled live. af_thresh=0 forces almost_full=1; ae_thresh ≥ DEPTH forces almost_empty=1.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through): rd_data = mem[rptr] combinationally whenever !empty; it is valid in the cycle after the first write lands. rd_acc pops the head, and the next word appears in the same cycle after the edge. rd_data is don't-care while empty. level counts the head word.
- Undefined: registered 1-cycle-latency read as specified above.

Decomposition:
- Package fifo_pkg:
  - default DATA_WIDTH/DEPTH constants;
  - fifo_status_t packed struct {full, empty, almost_full, almost_empty, half_full};
  - err_t {overflow, underflow}.
- Sub-module fifo_mem: DEPTH×DATA_WIDTH array, synchronous write, asynchronous read. The FIFO control, counter and flags stay in sync_fifo_prog.

Test Plan:
All scenarios use DATA_WIDTH=8, DEPTH=16, af_thresh=12, ae_thresh=3.
1. Reset: rstn=0 for 2 cycles -> level=0, empty=1, almost_empty=1, full=0, half_full=0, overflow/underflow=0, rd_data=0x00.
2. Fill: write 0x00..0x0F on consecutive cycles -> half_full rises when level=8, almost_full when level=12, full when level=16. A 17th write of 0xAA -> overflow=1, level stays 16, 0xAA is never read back.
3. Drain: 16 reads -> rd_data 0x00..0x0F in order, each 1 cycle after its rd_enb. A 17th read -> underflow=1, rd_data holds 0x0F, empty=1. Then err_clr -> both sticky bits 0.
4. Simultaneous: wr+rd at level 16 -> level 16, overflow stays 0. wr+rd at level 0 -> level 1, underflow=1, the written word is read correctly afterward.
5. Flush: at level 10, assert flush with wr_enb=1 -> next cycle level=0, empty=1, almost_empty=1. The write is discarded, overflow=0 and rd_data is unchanged.
6. Wrap/FWFT: hold level 5 and issue 40 paired wr/rd with data = cycle index -> output order is exact across pointer wrap. With SYNC_FIFO_FWFT_EN, one write of 0x5A into an empty FIFO -> empty=0 and rd_data=0x5A on the next cycle, with no rd_enb.
